// File: rtl/game_pkg.sv
// Shared game constants: FSM state encoding and the scroll-speed defaults
// used by game_ctrl, Ground and Jump.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  localparam int SPEED_W = 4;
  localparam logic [SPEED_W-1:0] GAME_SPEED_INIT = 4'd2;
  localparam logic [SPEED_W-1:0] GAME_SPEED_MAX  = 4'd12;

endpackage

// File: rtl/game_ctrl_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge pulse;
// the one-CLK pulse appears 3 CLK after the asynchronous input rises.
module edge_sync (
  input  logic CLK,
  input  logic clrn,
  input  logic d,
  output logic pulse
);

  logic s1_q, s2_q, s3_q, pulse_q;

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= d;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pulse_q <= s2_q & ~s3_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// Dinosaur-runner sequencer: IDLE/RUN/OVER FSM, per-frame tick, collision latch, speed/score.
// Define GAME_CTRL_HISCORE_EN to add the hiscore output (best score since reset).
module game_ctrl
  import game_pkg::*;
#(
  parameter logic [SPEED_W-1:0] SPEED_INIT        = GAME_SPEED_INIT,
  parameter logic [SPEED_W-1:0] SPEED_MAX         = GAME_SPEED_MAX,
  parameter int                 SPEED_STEP_FRAMES = 600,
  parameter int                 SCORE_DIV         = 6,
  parameter int                 HOLD_FRAMES       = 60,
  parameter int                 SCORE_W           = 16
) (
  input  logic               CLK,
  input  logic               clrn,
  input  logic               btn_jump,
  input  logic               vs,
  input  logic               px_dino,
  input  logic               px_obst,
  output logic               game_status,
  output logic               game_over,
  output logic [SPEED_W-1:0] speed,
  output logic [SCORE_W-1:0] score,
`ifdef GAME_CTRL_HISCORE_EN
  output logic [SCORE_W-1:0] hiscore,
`endif
  output logic               frame_tick
);

  localparam int SPD_CW  = (SPEED_STEP_FRAMES > 1) ? $clog2(SPEED_STEP_FRAMES) : 1;
  localparam int DIV_CW  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int HOLD_CW = $clog2(HOLD_FRAMES + 1);
  localparam logic [SPD_CW-1:0]  SPD_LAST  = SPD_CW'(SPEED_STEP_FRAMES - 1);
  localparam logic [DIV_CW-1:0]  DIV_LAST  = DIV_CW'(SCORE_DIV - 1);
  localparam logic [HOLD_CW-1:0] HOLD_FULL = HOLD_CW'(HOLD_FRAMES);

  logic tick, press, hit, start;

  state_e              state_q;
  logic                status_q, over_q, coll_q;
  logic [SPEED_W-1:0]  speed_q, speed_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SPD_CW-1:0]   spd_cnt_q, spd_cnt_d;
  logic [DIV_CW-1:0]   div_cnt_q, div_cnt_d;
  logic [HOLD_CW-1:0]  hold_q;
`ifdef GAME_CTRL_HISCORE_EN
  logic [SCORE_W-1:0]  hiscore_q;
`endif

  edge_sync u_vs_sync (
    .CLK   (CLK),
    .clrn  (clrn),
    .d     (vs),
    .pulse (tick)
  );

  edge_sync u_btn_sync (
    .CLK   (CLK),
    .clrn  (clrn),
    .d     (btn_jump),
    .pulse (press)
  );

  // Frame-update values; only committed on a RUN frame_tick.
  always_comb begin
    speed_d   = speed_q;
    score_d   = score_q;
    spd_cnt_d = spd_cnt_q + 1'b1;
    div_cnt_d = div_cnt_q + 1'b1;
    if (spd_cnt_q == SPD_LAST) begin
      spd_cnt_d = '0;
      if (speed_q < SPEED_MAX) speed_d = speed_q + 1'b1;
    end
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      if (score_q != '1) score_d = score_q + 1'b1;
    end
  end

  assign hit   = px_dino & px_obst & (state_q == ST_RUN);
  assign start = press & ((state_q == ST_IDLE) ||
                          ((state_q == ST_OVER) && (hold_q == HOLD_FULL)));

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      status_q  <= 1'b0;
      over_q    <= 1'b0;
      coll_q    <= 1'b0;
      speed_q   <= SPEED_INIT;
      score_q   <= '0;
      spd_cnt_q <= '0;
      div_cnt_q <= '0;
      hold_q    <= '0;
`ifdef GAME_CTRL_HISCORE_EN
      hiscore_q <= '0;
`endif
    end else begin
      // A hit on the tick cycle itself carries into the next frame.
      coll_q <= tick ? hit : (coll_q | hit);
      if (start) begin
        state_q   <= ST_RUN;
        status_q  <= 1'b1;
        over_q    <= 1'b0;
        speed_q   <= SPEED_INIT;
        score_q   <= '0;
        spd_cnt_q <= '0;
        div_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_RUN: begin
            if (tick) begin
              speed_q   <= speed_d;
              score_q   <= score_d;
              spd_cnt_q <= spd_cnt_d;
              div_cnt_q <= div_cnt_d;
              if (coll_q) begin
                state_q  <= ST_OVER;
                status_q <= 1'b0;
                over_q   <= 1'b1;
                hold_q   <= '0;
`ifdef GAME_CTRL_HISCORE_EN
                if (score_d > hiscore_q) hiscore_q <= score_d;
`endif
              end
            end
          end
          ST_OVER: begin
            if (tick && (hold_q != HOLD_FULL)) hold_q <= hold_q + 1'b1;
          end
          default: begin
            state_q  <= ST_IDLE;
            status_q <= 1'b0;
            over_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign game_status = status_q;
  assign game_over   = over_q;
  assign speed       = speed_q;
  assign score       = score_q;
  assign frame_tick  = tick;
`ifdef GAME_CTRL_HISCORE_EN
  assign hiscore     = hiscore_q;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: one default instance (a) and one with a 4-frame speed step (b),
// both driven by the same button/vsync/pixel stimulus.
module tb_game_ctrl;
  import game_pkg::*;

  logic        CLK = 1'b0;
  logic        clrn, btn_jump, vs, px_dino, px_obst;
  logic        st_a, ov_a, tick_a, st_b, ov_b, tick_b;
  logic [3:0]  spd_a, spd_b;
  logic [15:0] sc_a, sc_b;
`ifdef GAME_CTRL_HISCORE_EN
  logic [15:0] hi_a, hi_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int tp, tc;

  always #5 CLK = ~CLK;

  game_ctrl u_dut_a (
    .CLK(CLK), .clrn(clrn), .btn_jump(btn_jump), .vs(vs),
    .px_dino(px_dino), .px_obst(px_obst),
    .game_status(st_a), .game_over(ov_a), .speed(spd_a), .score(sc_a),
`ifdef GAME_CTRL_HISCORE_EN
    .hiscore(hi_a),
`endif
    .frame_tick(tick_a)
  );

  game_ctrl #(.SPEED_STEP_FRAMES(4)) u_dut_b (
    .CLK(CLK), .clrn(clrn), .btn_jump(btn_jump), .vs(vs),
    .px_dino(px_dino), .px_obst(px_obst),
    .game_status(st_b), .game_over(ov_b), .speed(spd_b), .score(sc_b),
`ifdef GAME_CTRL_HISCORE_EN
    .hiscore(hi_b),
`endif
    .frame_tick(tick_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Speed of instance b after n RUN frames: +1 every 4 frames, capped at 12.
  function automatic int exp_spd_b(input int n);
    return (2 + n / 4 > 12) ? 12 : 2 + n / 4;
  endfunction

  // One 8-CLK frame starting at a negedge; vs high for 2 CLK. Optional 1-CLK collision at cycle 5.
  task automatic frame(input bit coll, output int tpos, output int tcnt);
    tpos = 0;
    tcnt = 0;
    vs = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      if (i == 2) vs = 1'b0;
      if (tick_a) begin
        tcnt++;
        tpos = i;
      end
      px_dino = coll && (i == 5);
      px_obst = coll && (i == 5);
    end
  endtask

  task automatic press();
    btn_jump = 1'b1;
    repeat (3) @(negedge CLK);
    btn_jump = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    clrn = 1'b0; btn_jump = 1'b0; vs = 1'b0; px_dino = 1'b0; px_obst = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_status", st_a, 0);
    chk("rst_over", ov_a, 0);
    chk("rst_speed", spd_a, 2);
    chk("rst_score", sc_a, 0);
    chk("rst_tick", tick_a, 0);
    clrn = 1'b1;
    @(negedge CLK);

    for (int f = 0; f < 5; f++) begin
      frame(1'b0, tp, tc);
      chk("idle_tick_pos", tp, 3);
      chk("idle_tick_cnt", tc, 1);
    end
    chk("idle_status", st_a, 0);
    chk("idle_score", sc_a, 0);
    chk("idle_speed", spd_a, 2);

    press();
    chk("run_status", st_a, 1);
    chk("run_over", ov_a, 0);
    for (int j = 1; j <= 64; j++) begin
      frame(1'b0, tp, tc);
      chk("run_speed_b", spd_b, exp_spd_b(j));
      if (j == 18) begin
        chk("f18_score", sc_a, 3);
        chk("f18_speed", spd_a, 2);
        chk("f18_status", st_a, 1);
      end
    end
    chk("f64_score", sc_a, 10);
    chk("f64_speed", spd_a, 2);

    frame(1'b1, tp, tc);
    chk("coll_frame_status", st_a, 1);
    chk("coll_frame_score", sc_a, 10);
    press();
    chk("run_press_ignored", st_a, 1);
    frame(1'b0, tp, tc);
    chk("over_status", st_a, 0);
    chk("over_flag", ov_a, 1);
    chk("over_score", sc_a, 11);
    chk("over_speed_a", spd_a, 2);
    chk("over_speed_b", spd_b, 12);
`ifdef GAME_CTRL_HISCORE_EN
    chk("hiscore_g1", hi_a, 11);
`endif

    repeat (30) frame(1'b0, tp, tc);
    press();
    chk("over_press_h30", ov_a, 1);
    repeat (29) frame(1'b0, tp, tc);
    press();
    chk("over_press_h59", ov_a, 1);
    frame(1'b0, tp, tc);
    chk("over_score_frozen", sc_a, 11);
    chk("over_speed_frozen", spd_b, 12);
    press();
    chk("restart_status", st_a, 1);
    chk("restart_over", ov_a, 0);
    chk("restart_score", sc_a, 0);
    chk("restart_speed_a", spd_a, 2);
    chk("restart_speed_b", spd_b, 2);

    repeat (22) frame(1'b0, tp, tc);
    frame(1'b1, tp, tc);
    frame(1'b0, tp, tc);
    chk("g2_over", ov_a, 1);
    chk("g2_score", sc_a, 4);
    chk("g2_speed_b", spd_b, 8);
`ifdef GAME_CTRL_HISCORE_EN
    chk("hiscore_g2", hi_a, 11);
`endif

    repeat (60) frame(1'b0, tp, tc);
    press();
    chk("g3_status", st_a, 1);
    repeat (7) frame(1'b0, tp, tc);
    chk("g3_score", sc_a, 1);
    chk("g3_speed_b", spd_b, 3);

    #2 clrn = 1'b0;
    #1;
    chk("arst_status", st_a, 0);
    chk("arst_over", ov_a, 0);
    chk("arst_score", sc_a, 0);
    chk("arst_speed_b", spd_b, 2);
    chk("arst_tick", tick_a, 0);
`ifdef GAME_CTRL_HISCORE_EN
    chk("arst_hiscore", hi_a, 0);
`endif
    @(negedge CLK);
    clrn = 1'b1;
    frame(1'b0, tp, tc);
    chk("post_rst_tick", tc, 1);
    chk("post_rst_status", st_a, 0);
    chk("post_rst_score", sc_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Central game-sequencing controller for the dinosaur runner. Owns the IDLE/RUN/OVER state machine, derives a per-frame tick from the VGA vertical sync, and detects dinosaur/obstacle collisions from the pixel streams. Drives game_status and speed to the Jump and Ground blocks and exports a score counter. Sits in Top between the button/VGA inputs and the game datapath blocks.

Parameters:
SPEED_INIT, 4'd2, speed loaded on entry to RUN
SPEED_MAX, 4'd12, saturation ceiling for speed
SPEED_STEP_FRAMES, 600, RUN frames between speed increments
SCORE_DIV, 6, RUN frames per score increment
HOLD_FRAMES, 60, frames in OVER before a restart press is accepted
SCORE_W, 16, score width

Ports:
CLK  in  1  system clock; the only clock
clrn  in  1  reset; asynchronous assert, active-low
btn_jump  in  1  debounced jump/start button, level, active-high
vs  in  1  VGA vertical sync, asynchronous to CLK
px_dino  in  1  current pixel belongs to the dinosaur
px_obst  in  1  current pixel belongs to an obstacle
game_status  out  1  1 = RUN, 0 = IDLE/OVER
game_over  out  1  1 in OVER state
speed  out  4  scroll speed to Ground
score  out  SCORE_W  binary score
frame_tick  out  1  one-CLK pulse per frame

Behaviour:
- Reset (clrn=0, async): state=IDLE; game_status=0, game_over=0, speed=SPEED_INIT, score=0, frame_tick=0; all counters, sync flops and the collision latch cleared.
- vs goes through a 2-flop synchroniser then a rising-edge detector; frame_tick = 1 CLK after the detected edge (3 CLK latency from the vs edge). Exactly one pulse per vs rising edge.
- btn_jump goes through a 2-flop synchroniser; press = 0->1 edge, one CLK wide.
- Collision latch: set on any CLK where px_dino&px_obst, state=RUN. Cleared on the CLK frame_tick is high (after evaluation). A set on that same CLK is kept for the next frame.
- FSM, 2-bit encoding IDLE=00, RUN=01, OVER=10; 11 is illegal, returns to IDLE next CLK.
  IDLE: press -> RUN; score<=0, speed<=SPEED_INIT, frame counters<=0.
  RUN: frame_tick with latch set -> OVER; hold counter<=0. Presses ignored (they belong to Jump).
  OVER: hold counter increments on frame_tick, saturating at HOLD_FRAMES. Press while hold counter==HOLD_FRAMES -> RUN, with the same initialisation as from IDLE. Earlier presses are discarded, not queued.
- Speed: in RUN, a frame counter counts frame_ticks. When it reaches SPEED_STEP_FRAMES-1 it wraps to 0 and speed increments, saturating at SPEED_MAX. Speed is frozen in OVER and is not reset until the next RUN entry.
- Score: in RUN, a divider counts frame_ticks 0..SCORE_DIV-1. On wrap, score+1, saturating at all-ones (no wrap). Frozen in OVER.
- Collision and score/speed update on the same frame_tick: the state goes to OVER, and score and speed still take that frame's update.
- Outputs are registered. game_status/game_over change on the CLK after the transition condition.

Optional Feature:
GAME_CTRL_HISCORE_EN. When defined, adds output hiscore[SCORE_W-1:0]; reset value 0. On each RUN->OVER transition, hiscore<=max(hiscore, final score). hiscore survives restarts and is cleared only by clrn. When undefined, the port and register are absent and behaviour is otherwise identical.

Decomposition:
- Package game_pkg holds the state encoding constants (ST_IDLE, ST_RUN, ST_OVER), the speed width (4), and the SPEED_INIT/SPEED_MAX defaults shared with Ground and Jump.
- One natural sub-module: edge_sync, a 2-flop synchroniser plus rising-edge pulse. It is instantiated twice, for vs and btn_jump.

Test Plan:
- Reset, then 5 vs pulses with no press -> state IDLE, score=0, speed=2, frame_tick pulsed 5 times, each 3 CLK after the vs edge.
- Press in IDLE, then 18 frames with no collision -> game_status=1, score=3, speed=2.
- SPEED_STEP_FRAMES overridden to 4, run 60 frames -> speed steps 2,3,...,12 and holds at 12 (saturation).
- Assert px_dino&px_obst for 1 CLK mid-frame 10, plus a press in the same frame -> OVER at next frame_tick, game_status=0, score frozen at 1.
- In OVER, press at frame 30 -> ignored. Press at frame 61 -> RUN, score=0, speed=2.
- Pull clrn low mid-RUN for 1 CLK -> all outputs return to reset values asynchronously, state IDLE. With GAME_CTRL_HISCORE_EN defined, hiscore retains the maximum of two games (scores 7 then 4 -> hiscore=7).
